// File: rtl/rcs_pkg.sv
// rcs_pkg: state encoding, default sizes and counter-width helper shared by rcs_seq_addsub.
package rcs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    // Bits needed to count 0..n-1, never fewer than one.
    function automatic int cnt_w(input int n);
        int w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/rcs_chunk_add.sv
// rcs_chunk_add: combinational CHUNK-bit ripple chain of full-adder cells.
module rcs_chunk_add #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout     = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/rcs_seq_addsub.sv
// rcs_seq_addsub: multi-cycle add/subtract, CHUNK bits per cycle through one shared ripple chain.
// Define RCS_SAT_EN to saturate the result to the signed limit on overflow.
module rcs_seq_addsub
    import rcs_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = cnt_w(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [CHUNK-1:0] ch_sum;
    logic             ch_cout, ch_cmsb;

    // Operands shift right each RUN cycle, so the low chunk is always chunk cnt.
    rcs_chunk_add #(.CHUNK(CHUNK)) u_add (
        .a        (a_q[CHUNK-1:0]),
        .b        (b_q[CHUNK-1:0]),
        .cin      (carry_q),
        .sum      (ch_sum),
        .cout     (ch_cout),
        .c_msb_in (ch_cmsb)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = in_a;
                b_d     = in_sub ? ~in_b : in_b;
                carry_d = in_sub;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                res_d   = (res_q >> CHUNK) | (WIDTH'(ch_sum) << (WIDTH - CHUNK));
                carry_d = ch_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cout_d  = ch_cout;
                    ovf_d   = ch_cmsb ^ ch_cout;
                    state_d = DONE;
`ifdef RCS_SAT_EN
                    // An overflowed sum has the wrong sign, so a set result MSB means positive overflow.
                    if (ovf_d)
                        res_d = ch_sum[CHUNK-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`endif
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign out_res   = res_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

endmodule
